stream_demux_en: RTL and testbench

STREAM_DEMUX_EN -- requirements
Module: stream_demux_en

---
 rtl/stream_demux_en.sv | 85 ++++++++
 tb/tb_stream_demux_en.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/stream_demux_en.sv
// One-to-N stream demultiplexer with block enable, per-channel one-beat output slots,
// all-or-nothing broadcast, and drop accounting for out-of-range selects.
module stream_demux_en #(
  parameter int unsigned W = 8,
  parameter int unsigned N = 8,
  localparam int unsigned SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           En,
  input  logic           i_valid,
  output logic           i_ready,
  input  logic [W-1:0]   i,
  input  logic [SW-1:0]  S,
  input  logic           bcast,
  output logic [N*W-1:0] F,
  output logic [N-1:0]   F_valid,
  input  logic [N-1:0]   F_ready,
  output logic           err,
  output logic [7:0]     drop_cnt
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [N-1:0][W-1:0] data_q;
  logic [N-1:0]        valid_q;

  logic [N-1:0] tgt;
  logic [N-1:0] slot_free;
  logic [N-1:0] load;
  logic         s_in_range;
  logic         all_free;
  logic         accept;
  logic         drop;

  // Target decode, acceptance and drop detection; independent of i_valid for i_ready.
  always_comb begin
    tgt        = '0;
    s_in_range = (32'(S) < N);
    for (int unsigned k = 0; k < N; k++) begin
      tgt[k] = bcast || (s_in_range && (32'(S) == k));
    end
    slot_free = ~valid_q | F_ready;
    all_free  = &(slot_free | ~tgt);
    i_ready   = En && all_free;
    accept    = i_valid && i_ready;
    load      = accept ? tgt : '0;
    drop      = accept && !bcast && !s_in_range;
  end

  // Per-channel slot: load wins over drain so a slot can turn over every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      for (int unsigned k = 0; k < N; k++) begin
        if (load[k]) begin
          data_q[k]  <= i;
          valid_q[k] <= 1'b1;
        end else if (F_ready[k]) begin
          valid_q[k] <= 1'b0;
        end
      end
    end
  end

  // Sticky error flag and saturating drop counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err      <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      err <= 1'b1;
      if (drop_cnt != CNT_MAX) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end
  end

  assign F       = data_q;
  assign F_valid = valid_q;

endmodule

// File: tb/tb_stream_demux_en.sv
// Directed and randomized checks of stream_demux_en: an 8x8 instance plus a
// 6-channel instance for out-of-range select handling.
module tb_stream_demux_en;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 8 channels, 8 bits
  logic        en8, iv8, ir8, bc8, err8;
  logic [7:0]  i8;
  logic [2:0]  s8;
  logic [63:0] f8;
  logic [7:0]  fv8, fr8, dc8;

  // 6 channels, 8 bits
  logic        en6, iv6, ir6, bc6, err6;
  logic [7:0]  i6;
  logic [2:0]  s6;
  logic [47:0] f6;
  logic [5:0]  fv6, fr6;
  logic [7:0]  dc6;

  stream_demux_en #(.W(8), .N(8)) dut8 (
    .clk(clk), .rst(rst), .En(en8), .i_valid(iv8), .i_ready(ir8), .i(i8), .S(s8),
    .bcast(bc8), .F(f8), .F_valid(fv8), .F_ready(fr8), .err(err8), .drop_cnt(dc8)
  );

  stream_demux_en #(.W(8), .N(6)) dut6 (
    .clk(clk), .rst(rst), .En(en6), .i_valid(iv6), .i_ready(ir6), .i(i6), .S(s6),
    .bcast(bc6), .F(f6), .F_valid(fv6), .F_ready(fr6), .err(err6), .drop_cnt(dc6)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ch8(input int k);
    logic [63:0] v;
    v = f8;
    return v[k*8 +: 8];
  endfunction

  // Reference: one FIFO of expected beats per channel
  logic [7:0] q[8][$];

  task automatic rnd_step(input bit drain);
    logic [7:0] tgt;
    logic       exp_rdy;
    logic [7:0] exp_fv;
    @(negedge clk);
    if (drain) begin
      iv8 = 1'b0; fr8 = 8'hFF; en8 = 1'b1; bc8 = 1'b0;
    end else begin
      iv8 = ($urandom_range(0, 3) != 0);
      bc8 = ($urandom_range(0, 7) == 0);
      s8  = 3'($urandom_range(0, 7));
      i8  = 8'($urandom);
      fr8 = 8'($urandom);
      en8 = ($urandom_range(0, 9) != 0);
    end
    #1;
    exp_fv = '0;
    for (int k = 0; k < 8; k++) exp_fv[k] = (q[k].size() != 0);
    check("rnd_fvalid", 64'(fv8), 64'(exp_fv));
    tgt = bc8 ? 8'hFF : (8'h01 << s8);
    exp_rdy = en8;
    for (int k = 0; k < 8; k++)
      if (tgt[k] && q[k].size() != 0 && !fr8[k]) exp_rdy = 1'b0;
    check("rnd_iready", 64'(ir8), 64'(exp_rdy));
    for (int k = 0; k < 8; k++) begin
      if (fv8[k] && fr8[k] && q[k].size() != 0) begin
        check("rnd_data", 64'(ch8(k)), 64'(q[k].pop_front()));
      end
    end
    if (iv8 && exp_rdy) begin
      for (int k = 0; k < 8; k++) if (tgt[k]) q[k].push_back(i8);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int left;
    rst = 1'b1;
    en8 = 0; iv8 = 0; i8 = 0; s8 = 0; bc8 = 0; fr8 = 0;
    en6 = 0; iv6 = 0; i6 = 0; s6 = 0; bc6 = 0; fr6 = 0;
    #12;
    check("rst_fvalid", 64'(fv8), 64'h0);
    check("rst_f", f8, 64'h0);
    check("rst_err", 64'(err6), 64'h0);
    check("rst_drop", 64'(dc6), 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // Single beat to channel 3
    en8 = 1; s8 = 3; i8 = 8'hA5; iv8 = 1; fr8 = 8'hFF;
    #1 check("b1_ready", 64'(ir8), 64'h1);
    @(negedge clk);
    iv8 = 0;
    check("b1_fvalid", 64'(fv8), 64'h08);
    check("b1_data", 64'(ch8(3)), 64'hA5);
    @(negedge clk);
    check("b1_drained", 64'(fv8), 64'h0);
    check("b1_retain", 64'(ch8(3)), 64'hA5);

    // Backpressure on channel 3
    fr8 = 8'hF7; i8 = 8'h11; iv8 = 1;
    #1 check("bp_ready1", 64'(ir8), 64'h1);
    @(negedge clk);
    i8 = 8'h22;
    #1 check("bp_ready_stall", 64'(ir8), 64'h0);
    check("bp_hold1", 64'(ch8(3)), 64'h11);
    @(negedge clk);
    check("bp_ready_stall2", 64'(ir8), 64'h0);
    check("bp_hold2", 64'(ch8(3)), 64'h11);
    check("bp_fvalid", 64'(fv8), 64'h08);
    fr8 = 8'hFF;
    #1 check("bp_ready_free", 64'(ir8), 64'h1);
    @(negedge clk);
    iv8 = 0;
    check("bp_next", 64'(ch8(3)), 64'h22);
    check("bp_next_fvalid", 64'(fv8), 64'h08);
    @(negedge clk);
    check("bp_empty", 64'(fv8), 64'h0);

    // Broadcast blocked by full slot 0
    fr8 = 8'hFE; s8 = 0; i8 = 8'h77; iv8 = 1;
    @(negedge clk);
    bc8 = 1; i8 = 8'h5A;
    #1 check("bc_blocked", 64'(ir8), 64'h0);
    @(negedge clk);
    check("bc_blocked2", 64'(ir8), 64'h0);
    check("bc_partial", 64'(fv8), 64'h01);
    check("bc_slot0", 64'(ch8(0)), 64'h77);
    fr8 = 8'hFF;
    #1 check("bc_ready", 64'(ir8), 64'h1);
    @(negedge clk);
    iv8 = 0; bc8 = 0;
    check("bc_fvalid", 64'(fv8), 64'hFF);
    check("bc_data", f8, {8{8'h5A}});
    @(negedge clk);
    check("bc_empty", 64'(fv8), 64'h0);

    // Enable low blocks acceptance but not draining
    fr8 = 8'hFB; s8 = 2; i8 = 8'hC3; iv8 = 1;
    @(negedge clk);
    en8 = 0; fr8 = 8'hFF; s8 = 5; i8 = 8'h99;
    #1 check("en_ready", 64'(ir8), 64'h0);
    check("en_full", 64'(fv8), 64'h04);
    check("en_data", 64'(ch8(2)), 64'hC3);
    @(negedge clk);
    check("en_drain", 64'(fv8), 64'h0);
    check("en_noload", 64'(ch8(5)), 64'h5A);
    en8 = 1; iv8 = 0;
    #1 check("ready_no_valid", 64'(ir8), 64'h1);

    // Out-of-range select on the 6-channel instance
    en6 = 1; s6 = 7; i6 = 8'hEE; iv6 = 1; fr6 = '0;
    #1 check("oor_ready", 64'(ir6), 64'h1);
    @(negedge clk);
    check("oor_err1", 64'(err6), 64'h1);
    check("oor_cnt1", 64'(dc6), 64'h1);
    check("oor_fvalid1", 64'(fv6), 64'h0);
    left = 299;
    repeat (left) @(negedge clk);
    check("oor_cnt_sat", 64'(dc6), 64'd255);
    check("oor_err_sticky", 64'(err6), 64'h1);
    check("oor_fvalid", 64'(fv6), 64'h0);
    s6 = 5; i6 = 8'hE1;
    @(negedge clk);
    iv6 = 0;
    check("n6_ch5_valid", 64'(fv6), 64'h20);
    check("n6_ch5_data", 64'(f6[47:40]), 64'hE1);
    check("n6_cnt_hold", 64'(dc6), 64'd255);

    // Asynchronous reset mid-stream
    fr8 = 8'h00; bc8 = 1; i8 = 8'h42; iv8 = 1;
    @(negedge clk);
    iv8 = 0; bc8 = 0;
    check("mr_full", 64'(fv8), 64'hFF);
    #2 rst = 1'b1;
    #1;
    check("mr_fvalid", 64'(fv8), 64'h0);
    check("mr_f", f8, 64'h0);
    check("mr_err", 64'(err6), 64'h0);
    check("mr_cnt", 64'(dc6), 64'h0);
    check("mr_fvalid6", 64'(fv6), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    fr8 = 8'hFF; s8 = 1; i8 = 8'h3C; iv8 = 1;
    #1 check("pr_ready", 64'(ir8), 64'h1);
    @(negedge clk);
    iv8 = 0;
    check("pr_fvalid", 64'(fv8), 64'h02);
    check("pr_data", 64'(ch8(1)), 64'h3C);
    @(negedge clk);

    // Randomized traffic against per-channel queues
    for (int n = 0; n < 10000; n++) rnd_step(1'b0);
    for (int n = 0; n < 3; n++) rnd_step(1'b1);
    left = 0;
    for (int k = 0; k < 8; k++) left += q[k].size();
    check("rnd_leftover", 64'(left), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
